ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have ports clk_i input 1 (clock); rst_i input 1 (reset).
REQ-002 SHALL use one clock, clk_i; reset rst_i is asynchronous and active-low.
REQ-003 SHALL have id_valid_i input 1 (ID bundle valid); id_ready_o output 1 (stage can accept).
REQ-004 SHALL have id_rs_data_i, id_rt_data_i, id_imm_i input 32 each (register operands, sign-extended immediate).
REQ-005 SHALL have id_alusrc_i input 1 (1 = immediate as operand 2); id_aluctrl_i input 4 (ALU op code); id_regwrite_i input 1.
REQ-006 SHALL have id_rs_i, id_rt_i, id_wa_i input 5 each (source and destination register numbers).
REQ-007 SHALL have flush_i input 1 (squash held and incoming instruction).
REQ-008 SHALL have exm_regwrite_i input 1, exm_wa_i input 5, exm_data_i input 32 (EX/MEM forwarding source).
REQ-009 SHALL have wb_regwrite_i input 1, wb_wa_i input 5, wb_data_i input 32 (MEM/WB forwarding source).
REQ-010 SHALL have ex_valid_o output 1; ex_ready_i input 1 (downstream accepts).
REQ-011 SHALL have src1_o, src2_o output 32 (ALU operands); ctrl_o output 4 (ALU op code); store_data_o output 32 (forwarded rt value).
REQ-012 SHALL have wa_o output 5; regwrite_o output 1.

Function
REQ-013 SHALL hold one instruction entry: rs/rt data, imm, alusrc, aluctrl, rs, rt, wa, regwrite, valid.
REQ-014 SHALL drive id_ready_o = !ex_valid_o || ex_ready_i, combinationally.
REQ-015 SHALL capture all id_* fields on the rising edge when id_valid_i && id_ready_o && !flush_i, and set valid to 1.
REQ-016 SHALL clear valid on the edge when ex_valid_o && ex_ready_i and no capture occurs.
REQ-017 SHALL give flush_i priority over capture and hold: the next edge clears valid and drops the incoming bundle.
REQ-018 SHALL define fwd(r, d) = exm_data_i if exm_regwrite_i && exm_wa_i==r && r!=0; else wb_data_i if wb_regwrite_i && wb_wa_i==r && r!=0; else d.
REQ-019 SHALL give EX/MEM priority over WB when both match.
REQ-020 SHALL never forward register 0; held data passes unchanged.
REQ-021 SHALL drive src1_o = fwd(rs, rs_data) combinationally from the held entry.
REQ-022 SHALL drive store_data_o = fwd(rt, rt_data).
REQ-023 SHALL drive src2_o = imm when alusrc=1, else store_data_o.
REQ-024 SHALL drive ctrl_o and wa_o from the held fields.
REQ-025 SHALL drive regwrite_o = held regwrite && ex_valid_o.
REQ-026 SHALL, on each edge while ex_valid_o && !ex_ready_i && !flush_i, overwrite held rs_data and rt_data with their forwarded values, so a forwarded result survives a stall after its source retires.
REQ-027 SHALL take the new bundle, not the retiring one, when accepting (ex_ready_i=1) and capturing on the same edge.
REQ-028 SHALL perform no arithmetic; all data paths SHALL be 32-bit pass/select only.

Reset
REQ-029 SHALL, while rst_i=0, asynchronously clear all held fields to 0 and valid to 0.
REQ-030 SHALL therefore drive ex_valid_o=0, regwrite_o=0, src1_o=0, src2_o=0, ctrl_o=0, wa_o=0, store_data_o=0 and id_ready_o=1 during reset.
REQ-031 SHALL discard any held instruction on reset mid-stall; the first capture is allowed on the first edge after rst_i rises.

Verification
REQ-032 SHALL cover basic pass: capture rs_data=5, rt_data=7, alusrc=0, aluctrl=0010, no forwarding -> next cycle ex_valid_o=1, src1_o=5, src2_o=7, ctrl_o=0010.
REQ-033 SHALL cover forward priority: held rs=3, exm_wa=3 (data 0xAA), wb_wa=3 (data 0xBB), both regwrite=1 -> src1_o=0xAA; with exm_regwrite=0 -> 0xBB.
REQ-034 SHALL cover register 0: held rs=0, exm_wa=0, exm_regwrite=1, exm_data=0xFF -> src1_o equals the held rs_data.
REQ-035 SHALL cover stall latch: ex_ready_i=0, wb forwards 0x1234 to rt for 1 cycle then wb_regwrite=0 -> store_data_o stays 0x1234, and id_ready_o=0 throughout.
REQ-036 SHALL cover flush vs capture: id_valid_i=1 and flush_i=1 on the same edge -> next cycle ex_valid_o=0, regwrite_o=0.
REQ-037 SHALL cover immediate plus async reset: alusrc=1, imm=0xFFFFFFFC -> src2_o=0xFFFFFFFC; then rst_i=0 mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: single-entry ID->EX pipeline register with operand forwarding.
//
// Holds one decoded instruction and presents its ALU operands. Register
// operands are forwarded from the EX/MEM stage first, then from MEM/WB.
// While the stage is stalled, the forwarded values are written back into the
// entry. A result that has been forwarded therefore stays valid after its
// producer leaves the forwarding window.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   id_valid_i / id_ready_o      upstream handshake (ID bundle in)
//   id_rs_data_i, id_rt_data_i   register operand values from ID
//   id_imm_i                     sign-extended immediate
//   id_alusrc_i, id_aluctrl_i    operand-2 select, ALU op code
//   id_regwrite_i                instruction writes a register
//   id_rs_i, id_rt_i, id_wa_i    source / destination register numbers
//   flush_i                      squash held and incoming instruction
//   exm_*, wb_*                  forwarding sources (EX/MEM, MEM/WB)
//   ex_valid_o / ex_ready_i      downstream handshake
//   src1_o, src2_o, ctrl_o       ALU operands and op code
//   store_data_o                 forwarded rt value
//   wa_o, regwrite_o             destination register and write enable
module ex_operand_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_rt_data_i,
  input  logic [31:0] id_imm_i,
  input  logic        id_alusrc_i,
  input  logic [3:0]  id_aluctrl_i,
  input  logic        id_regwrite_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_wa_i,
  input  logic        flush_i,
  input  logic        exm_regwrite_i,
  input  logic [4:0]  exm_wa_i,
  input  logic [31:0] exm_data_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_wa_i,
  input  logic [31:0] wb_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [3:0]  ctrl_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  wa_o,
  output logic        regwrite_o
);

  logic        valid_q,    valid_d;
  logic [31:0] rs_data_q,  rs_data_d;
  logic [31:0] rt_data_q,  rt_data_d;
  logic [31:0] imm_q,      imm_d;
  logic        alusrc_q,   alusrc_d;
  logic [3:0]  aluctrl_q,  aluctrl_d;
  logic [4:0]  rs_q,       rs_d;
  logic [4:0]  rt_q,       rt_d;
  logic [4:0]  wa_q,       wa_d;
  logic        regwrite_q, regwrite_d;

  logic        capture;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // Register 0 is hard-wired, so it is never a forwarding target.
  always_comb begin
    rs_fwd = rs_data_q;
    if (exm_regwrite_i && (exm_wa_i == rs_q) && (rs_q != 5'd0)) begin
      rs_fwd = exm_data_i;
    end else if (wb_regwrite_i && (wb_wa_i == rs_q) && (rs_q != 5'd0)) begin
      rs_fwd = wb_data_i;
    end
  end

  always_comb begin
    rt_fwd = rt_data_q;
    if (exm_regwrite_i && (exm_wa_i == rt_q) && (rt_q != 5'd0)) begin
      rt_fwd = exm_data_i;
    end else if (wb_regwrite_i && (wb_wa_i == rt_q) && (rt_q != 5'd0)) begin
      rt_fwd = wb_data_i;
    end
  end

  always_comb begin
    id_ready_o   = !valid_q || ex_ready_i;
    ex_valid_o   = valid_q;
    src1_o       = rs_fwd;
    store_data_o = rt_fwd;
    src2_o       = alusrc_q ? imm_q : rt_fwd;
    ctrl_o       = aluctrl_q;
    wa_o         = wa_q;
    regwrite_o   = regwrite_q && valid_q;
  end

  assign capture = id_valid_i && id_ready_o && !flush_i;

  always_comb begin
    valid_d    = valid_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    wa_d       = wa_q;
    regwrite_d = regwrite_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d    = 1'b1;
      rs_data_d  = id_rs_data_i;
      rt_data_d  = id_rt_data_i;
      imm_d      = id_imm_i;
      alusrc_d   = id_alusrc_i;
      aluctrl_d  = id_aluctrl_i;
      rs_d       = id_rs_i;
      rt_d       = id_rt_i;
      wa_d       = id_wa_i;
      regwrite_d = id_regwrite_i;
    end else if (valid_q && ex_ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: keep forwarded operands so they outlive their producers.
      rs_data_d = rs_fwd;
      rt_data_d = rt_fwd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wa_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wa_q       <= wa_d;
      regwrite_q <= regwrite_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc;
  logic [3:0]  id_aluctrl;
  logic        id_regwrite;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        flush;
  logic        exm_regwrite;
  logic [4:0]  exm_wa;
  logic [31:0] exm_data;
  logic        wb_regwrite;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] src1, src2, store_data;
  logic [3:0]  ctrl;
  logic [4:0]  wa;
  logic        regwrite;

  int n_err = 0;
  int n_chk = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .id_valid_i    (id_valid),
    .id_ready_o    (id_ready),
    .id_rs_data_i  (id_rs_data),
    .id_rt_data_i  (id_rt_data),
    .id_imm_i      (id_imm),
    .id_alusrc_i   (id_alusrc),
    .id_aluctrl_i  (id_aluctrl),
    .id_regwrite_i (id_regwrite),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_wa_i       (id_wa),
    .flush_i       (flush),
    .exm_regwrite_i(exm_regwrite),
    .exm_wa_i      (exm_wa),
    .exm_data_i    (exm_data),
    .wb_regwrite_i (wb_regwrite),
    .wb_wa_i       (wb_wa),
    .wb_data_i     (wb_data),
    .ex_valid_o    (ex_valid),
    .ex_ready_i    (ex_ready),
    .src1_o        (src1),
    .src2_o        (src2),
    .ctrl_o        (ctrl),
    .store_data_o  (store_data),
    .wa_o          (wa),
    .regwrite_o    (regwrite)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic        alusrc;
    logic [3:0]  aluctrl;
    logic [4:0]  rs, rt, wa;
    logic        regwrite;
  } entry_t;

  entry_t m_ent = '{default: '0};
  bit     m_valid = 1'b0;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (exm_regwrite && exm_wa == r) return exm_data;
    if (wb_regwrite && wb_wa == r) return wb_data;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ent   = '{default: '0};
      m_valid = 1'b0;
    end else begin
      bit accept_ok;
      accept_ok = !m_valid || ex_ready;
      if (flush) begin
        m_valid = 1'b0;
      end else if (id_valid && accept_ok) begin
        m_ent = '{rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                  alusrc: id_alusrc, aluctrl: id_aluctrl, rs: id_rs, rt: id_rt,
                  wa: id_wa, regwrite: id_regwrite};
        m_valid = 1'b1;
      end else if (m_valid && ex_ready) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        logic [31:0] a, b;
        a = fwd(m_ent.rs, m_ent.rs_data);
        b = fwd(m_ent.rt, m_ent.rt_data);
        m_ent.rs_data = a;
        m_ent.rt_data = b;
      end
    end
  end

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] st;
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
      chk("regwrite", 32'(regwrite), 32'(m_valid && m_ent.regwrite));
      if (m_valid) begin
        st = fwd(m_ent.rt, m_ent.rt_data);
        chk("src1", src1, fwd(m_ent.rs, m_ent.rs_data));
        chk("store_data", store_data, st);
        chk("src2", src2, m_ent.alusrc ? m_ent.imm : st);
        chk("ctrl", 32'(ctrl), 32'(m_ent.aluctrl));
        chk("wa", 32'(wa), 32'(m_ent.wa));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
    id_aluctrl = 0; id_regwrite = 0; id_rs = 0; id_rt = 0; id_wa = 0;
    flush = 0; exm_regwrite = 0; exm_wa = 0; exm_data = 0;
    wb_regwrite = 0; wb_wa = 0; wb_data = 0; ex_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                     input logic [31:0] rtd, input logic alusrc, input logic [31:0] imm,
                     input logic [3:0] ctl, input logic [4:0] wad, input logic rw);
    id_valid = 1; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
    id_alusrc = alusrc; id_imm = imm; id_aluctrl = ctl; id_wa = wad; id_regwrite = rw;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_regwrite"}, 32'(regwrite), 32'd0);
    chk({tag, "_src1"}, src1, 32'd0);
    chk({tag, "_src2"}, src2, 32'd0);
    chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
    chk({tag, "_wa"}, 32'(wa), 32'd0);
    chk({tag, "_store"}, store_data, 32'd0);
    chk({tag, "_ready"}, 32'(id_ready), 32'd1);
  endtask

  initial begin
    idle();
    #3;
    chk_all_zero("reset");
    cmp_en = 1'b1;
    #9 rst_n = 1'b1;
    tick();

    // Basic pass
    put(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 4'b0010, 5'd3, 1'b1);
    tick();
    idle();
    #1;
    chk("basic_valid", 32'(ex_valid), 32'd1);
    chk("basic_src1", src1, 32'd5);
    chk("basic_src2", src2, 32'd7);
    chk("basic_ctrl", 32'(ctrl), 32'b0010);
    chk("basic_regwrite", 32'(regwrite), 32'd1);

    // Forward priority
    put(5'd3, 32'h11, 5'd6, 32'h22, 1'b0, 32'd0, 4'd1, 5'd7, 1'b0);
    tick();
    idle();
    exm_regwrite = 1; exm_wa = 5'd3; exm_data = 32'hAA;
    wb_regwrite = 1; wb_wa = 5'd3; wb_data = 32'hBB;
    #1 chk("fwd_exm_prio", src1, 32'hAA);
    exm_regwrite = 0;
    #1 chk("fwd_wb", src1, 32'hBB);
    idle();

    // Register 0 never forwarded
    put(5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 32'd0, 4'd3, 5'd1, 1'b1);
    tick();
    idle();
    exm_regwrite = 1; exm_wa = 5'd0; exm_data = 32'hFF;
    #1 chk("r0_src1", src1, 32'h55);
    chk("r0_store", store_data, 32'h66);
    idle();

    // Stall latch
    put(5'd5, 32'h9, 5'd4, 32'h11, 1'b0, 32'd0, 4'd4, 5'd2, 1'b1);
    tick();
    idle();
    ex_ready = 0;
    wb_regwrite = 1; wb_wa = 5'd4; wb_data = 32'h1234;
    #1 chk("stall_fwd", store_data, 32'h1234);
    chk("stall_ready0", 32'(id_ready), 32'd0);
    tick();
    wb_regwrite = 0; wb_data = 32'hDEAD;
    #1 chk("stall_keep", store_data, 32'h1234);
    chk("stall_src2", src2, 32'h1234);
    chk("stall_ready1", 32'(id_ready), 32'd0);
    tick();
    chk("stall_keep2", store_data, 32'h1234);
    ex_ready = 1;
    tick();
    chk("stall_drain", 32'(ex_valid), 32'd0);

    // Flush beats capture
    put(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'd0, 4'd5, 5'd9, 1'b1);
    flush = 1;
    tick();
    idle();
    #1 chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_regwrite", 32'(regwrite), 32'd0);

    // Immediate, then async reset mid-stall
    put(5'd1, 32'h3, 5'd2, 32'h4, 1'b1, 32'hFFFF_FFFC, 4'd6, 5'd8, 1'b1);
    tick();
    idle();
    ex_ready = 0;
    #1 chk("imm_src2", src2, 32'hFFFF_FFFC);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    put(5'd2, 32'h77, 5'd3, 32'h88, 1'b0, 32'd0, 4'd7, 5'd4, 1'b1);
    ex_ready = 1;
    #1 rst_n = 1'b1;
    tick();
    idle();
    #1 chk("post_rst_capture", 32'(ex_valid), 32'd1);
    chk("post_rst_src1", src1, 32'h77);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_valid     = ($urandom_range(0, 99) < 60);
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_alusrc    = 1'($urandom_range(0, 1));
      id_aluctrl   = 4'($urandom_range(0, 15));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_wa        = 5'($urandom_range(0, 31));
      flush        = ($urandom_range(0, 99) < 8);
      exm_regwrite = ($urandom_range(0, 99) < 40);
      exm_wa       = 5'($urandom_range(0, 7));
      exm_data     = $urandom;
      wb_regwrite  = ($urandom_range(0, 99) < 40);
      wb_wa        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      ex_ready     = ($urandom_range(0, 99) < 55);
      rst_n        = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
